// File: rtl/qdma_sched.sv
// ---------------------------------------------------------------------------
// qdma_sched
//
// Shares one QBUS DMA master engine (qmaster2908 + Am2908 DAL transceivers)
// among NREQ on-board DMA clients. A round-robin arbiter grants one client at
// a time. The granted request is latched locally, and the scheduler then runs
// the master's dma_read/dma_write handshake. It steers the client's address
// and then its write data onto the transceiver latch (TDAL), captures read
// data, and returns a one-cycle ack or err pulse to the client. A watchdog
// abandons any master cycle that does not finish within TIMEOUT cycles.
//
// Ports
//   qclk, reset_n            20 MHz clock, asynchronous active-low reset
//   req/rd/addr/wdata        per-client request level, direction (1=DATI),
//                            22-bit address and 16-bit write word (packed)
//   ack/err                  per-client completion / failure pulses
//   rdata                    last captured read word
//   busy                     a grant is active
//   dma_read/dma_write       request lines to the master engine
//   assert_addr/assert_data  master phase strobes
//   read_pulse               master strobe: BDAL carries read data
//   dma_complete/nxm         master cycle termination (ok / non-existent mem)
//   BDAL                     received DAL (non-inverted)
//   TDAL                     transmit DAL to the transceiver latch
// ---------------------------------------------------------------------------
module qdma_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              qclk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rd,
  input  logic [NREQ*22-1:0] addr,
  input  logic [NREQ*16-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              dma_read,
  output logic              dma_write,
  input  logic              assert_addr,
  input  logic              assert_data,
  input  logic              read_pulse,
  input  logic              dma_complete,
  input  logic              nxm,
  input  logic [21:0]       BDAL,
  output logic [21:0]       TDAL
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q,     state_d;
  logic [GW-1:0]   gnt_q,       gnt_d;
  logic [GW-1:0]   last_q,      last_d;
  logic            rd_q,        rd_d;
  logic [21:0]     addr_q,      addr_d;
  logic [15:0]     wdata_q,     wdata_d;
  logic [TW-1:0]   timer_q,     timer_d;
  logic            dma_read_q,  dma_read_d;
  logic            dma_write_q, dma_write_d;
  logic [NREQ-1:0] ack_q,       ack_d;
  logic [NREQ-1:0] err_q,       err_d;
  logic [15:0]     rdata_q,     rdata_d;
  logic            busy_q,      busy_d;

  logic            arb_found;
  logic [GW-1:0]   arb_idx;
  logic            timeout;
  logic            bdal_unused;

  // Only the low 16 DAL bits carry data words.
  assign bdal_unused = ^BDAL[21:16];

  assign timeout = (timer_q == TW'(TIMEOUT));

  // Round-robin search starting just after the last served client, so a
  // client that has just been served goes to the back of the line.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!arb_found && req[(int'(last_q) + k) % NREQ]) begin
        arb_found = 1'b1;
        arb_idx   = GW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // Next-state logic. The master request lines are registered, so they rise
  // one qclk after the grant edge. They are dropped on the edge that
  // terminates the phase (assert_data for writes, completion for reads).
  // Master responses are only honoured once the request is actually up.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    timer_d     = timer_q;
    dma_read_d  = dma_read_q;
    dma_write_d = dma_write_q;
    ack_d       = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          gnt_d   = arb_idx;
          rd_d    = rd[arb_idx];
          addr_d  = addr[int'(arb_idx)*22 +: 22];
          wdata_d = wdata[int'(arb_idx)*16 +: 16];
          timer_d = '0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        timer_d = timer_q + 1'b1;
        if (timeout || (nxm && (dma_read_q || dma_write_q))) begin
          dma_read_d   = 1'b0;
          dma_write_d  = 1'b0;
          err_d[gnt_q] = 1'b1;
          state_d      = S_DONE;
        end else if (rd_q) begin
          if (dma_complete && dma_read_q) begin
            dma_read_d   = 1'b0;
            ack_d[gnt_q] = 1'b1;
            state_d      = S_DONE;
          end else begin
            dma_read_d = 1'b1;
          end
        end else begin
          if (assert_data && dma_write_q) begin
            dma_write_d = 1'b0;
            state_d     = S_WAIT;
          end else begin
            dma_write_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (timeout || nxm) begin
          err_d[gnt_q] = 1'b1;
          state_d      = S_DONE;
        end else if (dma_complete) begin
          ack_d[gnt_q] = 1'b1;
          state_d      = S_DONE;
        end
      end

      default: begin
        last_d  = gnt_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Read data only follows BDAL while a read grant is in its issue phase;
    // repeated pulses overwrite, so the last one wins.
    if (state_q == S_ISSUE && rd_q && read_pulse) begin
      rdata_d = BDAL[15:0];
    end
  end

  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      last_q      <= GW'(NREQ - 1);
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      timer_q     <= '0;
      dma_read_q  <= 1'b0;
      dma_write_q <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      timer_q     <= timer_d;
      dma_read_q  <= dma_read_d;
      dma_write_q <= dma_write_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  // The watchdog drops the request in the very cycle it expires rather than
  // one edge later. The state qualifier keeps both lines low outside ISSUE.
  assign dma_read  = dma_read_q  && !timeout && (state_q == S_ISSUE);
  assign dma_write = dma_write_q && !timeout && (state_q == S_ISSUE);

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

  // Address phase wins over data phase. Reads never drive data outward.
  always_comb begin
    TDAL = '0;
    if (assert_addr) begin
      TDAL = addr_q;
    end else if (assert_data && !rd_q) begin
      TDAL = {6'b0, wdata_q};
    end
  end

endmodule

// File: tb/tb_qdma_sched.sv
// ---------------------------------------------------------------------------
// tb_qdma_sched
//
// Directed testbench for qdma_sched (NREQ=4, TIMEOUT=1023). The initial block
// plays both the clients and the master engine. Each issued transaction
// pushes its expected outcome onto a scoreboard queue. A negedge monitor pops
// and compares whenever the DUT pulses ack or err.
// ---------------------------------------------------------------------------
module tb_qdma_sched;

   localparam int NREQ = 4;

   logic              qclk;
   logic              reset_n;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   rd;
   logic [NREQ*22-1:0] addr;
   logic [NREQ*16-1:0] wdata;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   err;
   logic [15:0]       rdata;
   logic              busy;
   logic              dmaRead;
   logic              dmaWrite;
   logic              assertAddr;
   logic              assertData;
   logic              readPulse;
   logic              dmaComplete;
   logic              nxmIn;
   logic [21:0]       bdal;
   logic [21:0]       tdal;

   typedef struct {
      int          client;
      bit          isErr;
      bit          checkRd;
      logic [15:0] data;
   } exp_t;

   exp_t        expQ[$];
   int          testCount;
   int          failCount;
   logic [15:0] modelRdata;

   qdma_sched #(.NREQ(NREQ), .TIMEOUT(1023)) dut (
      .qclk(qclk),
      .reset_n(reset_n),
      .req(req),
      .rd(rd),
      .addr(addr),
      .wdata(wdata),
      .ack(ack),
      .err(err),
      .rdata(rdata),
      .busy(busy),
      .dma_read(dmaRead),
      .dma_write(dmaWrite),
      .assert_addr(assertAddr),
      .assert_data(assertData),
      .read_pulse(readPulse),
      .dma_complete(dmaComplete),
      .nxm(nxmIn),
      .BDAL(bdal),
      .TDAL(tdal)
   );

   // 20 MHz qclk
   initial begin
      qclk = 1'b0;
      forever #25 qclk = ~qclk;
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Load one client's request parameters and raise its req line
   task automatic applyStimulus(input int c, input bit r, input logic [21:0] a,
                                input logic [15:0] w);
      rd[c]            = r;
      addr[c*22 +: 22] = a;
      wdata[c*16 +: 16] = w;
      req[c]           = 1'b1;
   endtask

   // Acts as the master engine for one transaction. Called from an IDLE
   // cycle, so the grant edge is the next posedge and the request line must
   // be up after the second one. Ends in the IDLE cycle after DONE.
   task automatic runMaster(input int c, input bit isRead, input bit useNxm,
                            input bit doPulse, input logic [21:0] bdalVal,
                            input logic [21:0] expAddr, input logic [15:0] expWdata);
      int  n;
      bit  seen;
      exp_t e;
      if (isRead && doPulse) modelRdata = bdalVal[15:0];
      e.client  = c;
      e.isErr   = useNxm;
      e.checkRd = isRead;
      e.data    = modelRdata;
      expQ.push_back(e);

      seen = 1'b0;
      n    = 0;
      while (!seen && n < 20) begin
         @(posedge qclk); #1;
         n++;
         if (dmaRead || dmaWrite) seen = 1'b1;
      end
      checkOutput("request latency", n, 2);
      if (!seen) return;
      checkOutput("dma_read direction", dmaRead, isRead);
      checkOutput("dma_write direction", dmaWrite, !isRead);

      assertAddr = 1'b1;
      #1;
      checkOutput("TDAL address", tdal, expAddr);
      @(posedge qclk); #1;
      assertAddr = 1'b0;
      if (isRead) begin
         readPulse = doPulse;
         bdal      = bdalVal;
         #1;
         checkOutput("TDAL idle on read", tdal, 0);
         @(posedge qclk); #1;
         readPulse   = 1'b0;
         dmaComplete = !useNxm;
         nxmIn       = useNxm;
      end else begin
         assertData = 1'b1;
         #1;
         checkOutput("TDAL write data", tdal, {6'b0, expWdata});
         checkOutput("dma_write held in data phase", dmaWrite, 1);
         @(posedge qclk); #1;
         assertData = 1'b0;
         #1;
         checkOutput("dma_write drop after data", dmaWrite, 0);
         dmaComplete = !useNxm;
         nxmIn       = useNxm;
      end
      @(posedge qclk); #1;
      dmaComplete = 1'b0;
      nxmIn       = 1'b0;
      req[c]      = 1'b0;
      checkOutput("dma_read low in DONE", dmaRead, 0);
      checkOutput("dma_write low in DONE", dmaWrite, 0);
      @(posedge qclk); #1;
      checkOutput("busy low after DONE", busy, 0);
   endtask

   // Scoreboard monitor plus the request-exclusivity check
   always @(negedge qclk) begin
      if (reset_n) begin
         checkOutput("dma_read/dma_write exclusive", dmaRead & dmaWrite, 0);
         if (ack != 0 || err != 0) begin
            if (expQ.size() == 0) begin
               testCount++;
               failCount++;
               $display("[TB] FAIL unexpected completion: ack=%0h err=%0h, expected none", ack, err);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("ack vector", ack, e.isErr ? 32'd0 : (32'd1 << e.client));
               checkOutput("err vector", err, e.isErr ? (32'd1 << e.client) : 32'd0);
               if (e.checkRd) checkOutput("rdata at completion", rdata, e.data);
            end
         end
      end
   end

   initial begin
      int n;
      testCount   = 0;
      failCount   = 0;
      modelRdata  = 16'h0;
      reset_n     = 1'b0;
      req         = '0;
      rd          = '0;
      addr        = '0;
      wdata       = '0;
      assertAddr  = 1'b0;
      assertData  = 1'b0;
      readPulse   = 1'b0;
      dmaComplete = 1'b0;
      nxmIn       = 1'b0;
      bdal        = '0;

      // Reset values
      repeat (2) @(posedge qclk);
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset dma_read", dmaRead, 0);
      checkOutput("reset dma_write", dmaWrite, 0);
      checkOutput("reset ack", ack, 0);
      checkOutput("reset err", err, 0);
      checkOutput("reset rdata", rdata, 0);
      checkOutput("reset TDAL", tdal, 0);
      @(negedge qclk);
      reset_n = 1'b1;
      @(posedge qclk); #1;

      // Single write from client 0
      $display("[TB] single write");
      applyStimulus(0, 1'b0, 22'o777720, 16'o123432);
      runMaster(0, 1'b0, 1'b0, 1'b0, 22'h0, 22'o777720, 16'o123432);

      // Single read from client 2
      $display("[TB] single read");
      applyStimulus(2, 1'b1, 22'o001000, 16'h0);
      runMaster(2, 1'b1, 1'b0, 1'b1, 22'o054321, 22'o001000, 16'h0);

      // NXM on client 1 read, then client 2 is served (last=2 -> 3,0,1 first)
      $display("[TB] nxm");
      applyStimulus(1, 1'b1, 22'o002200, 16'h0);
      applyStimulus(2, 1'b1, 22'o003300, 16'h0);
      runMaster(1, 1'b1, 1'b1, 1'b0, 22'h0, 22'o002200, 16'h0);
      runMaster(2, 1'b1, 1'b0, 1'b1, 22'o017171, 22'o003300, 16'h0);

      // Watchdog on a client 3 write the master never answers
      $display("[TB] timeout");
      applyStimulus(3, 1'b0, 22'o600500, 16'o033333);
      begin
         exp_t e;
         e.client  = 3;
         e.isErr   = 1'b1;
         e.checkRd = 1'b0;
         e.data    = '0;
         expQ.push_back(e);
      end
      repeat (2) @(posedge qclk);
      #1;
      checkOutput("timeout dma_write up", dmaWrite, 1);
      n = 2;
      while (dmaWrite && n < 1100) begin
         @(posedge qclk); #1;
         n++;
      end
      checkOutput("timeout dma_write drop cycle", n, 1024);
      @(posedge qclk); #1;
      req[3] = 1'b0;
      @(posedge qclk); #1;
      checkOutput("timeout busy cleared", busy, 0);

      // Round robin: last=3, all four requesting -> 0,1,2,3,0,1
      $display("[TB] round robin");
      applyStimulus(0, 1'b0, 22'o200100, 16'o111111);
      applyStimulus(1, 1'b1, 22'o300200, 16'h0);
      applyStimulus(2, 1'b0, 22'o400300, 16'o022222);
      applyStimulus(3, 1'b1, 22'o500400, 16'h0);
      for (int it = 0; it < 6; it++) begin
         int c;
         c = it % 4;
         case (c)
            0: runMaster(0, 1'b0, 1'b0, 1'b0, 22'h0, 22'o200100, 16'o111111);
            1: runMaster(1, 1'b1, 1'b0, 1'b1, 22'(16'o010000 + it), 22'o300200, 16'h0);
            2: runMaster(2, 1'b0, 1'b0, 1'b0, 22'h0, 22'o400300, 16'o022222);
            default: runMaster(3, 1'b1, 1'b0, 1'b1, 22'o007700, 22'o500400, 16'h0);
         endcase
         if (it < 2) req[c] = 1'b1;
      end

      // Reset in the middle of a client 2 read (last=1 -> client 2 granted)
      $display("[TB] reset mid-read");
      applyStimulus(2, 1'b1, 22'o001234, 16'h0);
      repeat (2) @(posedge qclk);
      #1;
      checkOutput("mid-read dma_read up", dmaRead, 1);
      applyStimulus(0, 1'b0, 22'o002000, 16'o044444);
      #5;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset dma_read", dmaRead, 0);
      checkOutput("async reset busy", busy, 0);
      @(negedge qclk);
      reset_n = 1'b1;
      runMaster(0, 1'b0, 1'b0, 1'b0, 22'h0, 22'o002000, 16'o044444);
      runMaster(2, 1'b1, 1'b0, 1'b1, 22'o066066, 22'o001234, 16'h0);

      repeat (3) @(posedge qclk);
      #1;
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/qdma_sched.md
Name: qdma_sched

Overview:
- Shares the single QBUS DMA master engine (qmaster2908 plus the Am2908 DAL transceivers) among up to NREQ on-board DMA clients, such as the RK disk controller.
- Round-robin arbitration picks one client request at a time.
- Sequences the master's dma_read/dma_write handshake.
- Drives the transceiver latch input (TDAL) with the granted client's address, then its data.
- Captures read data on read_pulse.
- Returns per-client completion and error pulses.
- Includes a watchdog so a wedged master cycle cannot starve the other clients.

Parameters:
- NREQ, 4, number of DMA clients (2..8).
- TIMEOUT, 1023, qclk cycles from issue to dma_complete/nxm before the cycle is abandoned.

Ports:
- qclk  in  1  20 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-client DMA request; level, held until that client's ack or err.
- rd  in  NREQ  per-client direction: 1=read (DATI), 0=write (DATO).
- addr  in  NREQ*22  per-client 22-bit bus address; client i occupies [22i+21:22i].
- wdata  in  NREQ*16  per-client write word; client i occupies [16i+15:16i].
- ack  out  NREQ  one-cycle pulse: cycle completed OK.
- err  out  NREQ  one-cycle pulse: cycle failed (nxm or timeout).
- rdata  out  16  read word; valid in the ack cycle of a read and held until the next capture.
- busy  out  1  a grant is active.
- dma_read  out  1  request to master.
- dma_write  out  1  request to master.
- assert_addr  in  1  from master.
- assert_data  in  1  from master.
- read_pulse  in  1  from master.
- dma_complete  in  1  from master.
- nxm  in  1  from master.
- BDAL  in  22  received DAL (non-inverted).
- TDAL  out  22  transmit DAL to the transceiver latch.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; dma_read=dma_write=0; ack=err=0; busy=0; rdata=0; last=NREQ-1; timer=0.
  - Reset mid-cycle drops the master request at once. The client receives no ack/err.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, grant the first set index searching last+1, last+2, … modulo NREQ.
  - Latch gnt, rd[gnt], addr[gnt] and wdata[gnt] into local registers. Later client changes are ignored for this cycle.
  - Go to ISSUE. busy=1 from this edge.
  - If no req is set, stay in IDLE.
- ISSUE:
  - Drive dma_read=latched rd and dma_write=~latched rd. The first request is asserted 1 qclk after the grant edge.
  - Write: on the first qclk with assert_data=1, clear dma_write and go to WAIT.
  - Read: stay in ISSUE until dma_complete or nxm.
  - Either direction: nxm or timeout goes to DONE with failure.
- WAIT (write only): on dma_complete, go to DONE ok; on nxm or timeout, go to DONE fail.
- Read completion from ISSUE:
  - dma_complete clears dma_read and goes to DONE ok.
  - nxm clears dma_read and goes to DONE fail.
  - dma_complete and nxm in the same cycle counts as fail.
- DONE (exactly 1 cycle):
  - Pulse ack[gnt] or err[gnt].
  - Set last=gnt, busy=0, go to IDLE.
  - A client holding req re-arbitrates no earlier than 1 cycle after its ack. With other requesters pending, round-robin serves them first.
- Clients must drop req in the cycle after ack/err, or they are treated as a new request.
- rdata: loaded from BDAL[15:0] on every qclk with read_pulse=1 while a read grant is active. The last capture wins. Ignored when no read grant is active.
- TDAL:
  - assert_addr=1 → latched addr.
  - else assert_data=1 and latched rd=0 → {6'b0, latched wdata}.
  - else 22'b0.
  - Combinational from the latched registers. Both asserted: address wins.
- Timer:
  - Cleared on entry to ISSUE; increments each cycle in ISSUE/WAIT.
  - Timer==TIMEOUT forces dma_read=dma_write=0 → DONE fail.
- dma_read and dma_write are never both 1. Both are 0 outside ISSUE.
- Master inputs arriving while in IDLE/DONE are ignored.

Test Plan:
- Single write: client 0, addr=22'o777720, wdata=16'o123432 → dma_write rises 1 cycle after grant; TDAL=777720 during assert_addr and 000000123432 during assert_data; dma_write falls the cycle after assert_data; ack[0] pulses once after dma_complete; err=0.
- Single read: client 2, addr=22'o001000, BDAL=22'o054321 at read_pulse → rdata=16'o054321 in the ack[2] cycle; dma_read falls the cycle after dma_complete.
- Round robin: req=4'b1111 held (each client re-raises after ack) → grant order 0,1,2,3,0,1; never two acks in one cycle.
- NXM: client 1 read, master returns nxm instead of dma_complete → err[1] single pulse, ack=0, rdata unchanged, back to IDLE, next client served.
- Timeout: client 3 write, master never asserts assert_data/dma_complete → after 1023 cycles dma_write=0, err[3] pulses, busy=0.
- Reset mid-read: reset_n low while dma_read=1 → dma_read=0 and busy=0 immediately (async), no ack/err; after release, the pending req is granted starting at client 0.
